padder_acc: RTL and testbench

Parametrised, pipelined adder/accumulator with valid/ready handshakes on input and output. It is the next-generation demo datapath for Spacely-Caribou Cocotb tests. It generalises the clocked 4-bit adder in three ways: configurable operand width and pipeline depth, an accumulate mode with a sticky overflow flag, and an output result counter. A carry-error injection parameter is retained so that bench checkers can be proven to catch a broken carry chain.

---
 rtl/padder_acc.sv | 153 +++++++++++++++
 tb/tb_padder_acc.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/padder_acc.sv
// padder_acc: pipelined adder/accumulator with valid/ready handshakes.
//   Stage 1 computes A+B (add) or acc+A+B (accumulate) and snapshots the
//   sticky overflow flag; stages 2..STAGES are plain delay registers.
//   The whole pipeline freezes together while the output is stalled.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand beat handshake (in_ready is combinational)
//   A, B                  unsigned operands, WIDTH bits
//   mode                  0 = add, 1 = accumulate (sampled on accepted beat)
//   clear                 zero accumulator and sticky flag on accepted beat
//   out_valid / out_ready result beat handshake
//   Z                     unsigned result, WIDTH+1 bits
//   ovf                   sticky overflow state travelling with the result
//   res_count             number of completed output handshakes (wraps)
module padder_acc #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned STAGES      = 2,
    parameter int unsigned CARRY_ERROR = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mode,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   Z,
    output logic             ovf,
    output logic [15:0]      res_count
);

    localparam int unsigned ZW   = WIDTH + 1;
    localparam int unsigned SW   = WIDTH + 2;
    localparam int unsigned LAST = STAGES - 1;
    localparam int unsigned CW   = 16;

    logic [STAGES-1:0]          valid_q, valid_d, valid_shift;
    logic [STAGES-1:0][ZW-1:0]  z_q, z_d, z_shift;
    logic [STAGES-1:0]          ovf_q, ovf_d, ovf_shift;
    logic [ZW-1:0]              acc_q, acc_d;
    logic                       sticky_q, sticky_d;
    logic [CW-1:0]              cnt_q, cnt_d;

    logic                       advance;
    logic                       accept;
    logic                       take;
    logic [ZW-1:0]              base;
    logic                       base_sticky;
    logic [SW-1:0]              true_sum;
    logic [ZW-1:0]              add_sum;
    logic [ZW-1:0]              acc_sum;
    logic                       acc_ovf;
    logic [ZW-1:0]              z_new;
    logic                       ovf_new;

    // Handshake: the pipeline moves whenever the last stage can drain.
    always_comb begin
        advance  = out_ready || !valid_q[LAST];
        accept   = in_valid && advance;
        take     = valid_q[LAST] && out_ready;
        in_ready = advance;
    end

    // Stage-1 arithmetic; clear is folded into the base before summing.
    always_comb begin
        base        = clear ? '0 : acc_q;
        base_sticky = clear ? 1'b0 : sticky_q;
        true_sum    = SW'(base) + SW'(A) + SW'(B);
        add_sum     = ZW'(A) + ZW'(B);
        acc_sum     = true_sum[ZW-1:0];
        // Overflow is judged on the true sum even when the carry bit is broken.
        acc_ovf     = base_sticky | true_sum[SW-1];
        if (CARRY_ERROR != 0) begin
            add_sum[WIDTH] = 1'b0;
            acc_sum[WIDTH] = 1'b0;
        end
        if (accept) begin
            z_new   = mode ? acc_sum : add_sum;
            ovf_new = mode ? acc_ovf : base_sticky;
        end else begin
            z_new   = '0;
            ovf_new = 1'b0;
        end
    end

    // Stage shift vectors; a single-stage pipeline has nothing to delay.
    if (STAGES > 1) begin : g_shift
        assign valid_shift = {valid_q[STAGES-2:0], accept};
        assign z_shift     = {z_q[STAGES-2:0], z_new};
        assign ovf_shift   = {ovf_q[STAGES-2:0], ovf_new};
    end else begin : g_single
        assign valid_shift = accept;
        assign z_shift     = z_new;
        assign ovf_shift   = ovf_new;
    end

    // Next-state for pipeline, accumulator and result counter.
    always_comb begin
        valid_d  = valid_q;
        z_d      = z_q;
        ovf_d    = ovf_q;
        acc_d    = acc_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;

        if (take) begin
            cnt_d = cnt_q + CW'(1);
        end

        if (accept) begin
            // Add mode keeps acc unless clear zeroed it via base.
            acc_d    = mode ? acc_sum : base;
            sticky_d = mode ? acc_ovf : base_sticky;
        end

        if (advance) begin
            valid_d = valid_shift;
            z_d     = z_shift;
            ovf_d   = ovf_shift;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            z_q      <= '0;
            ovf_q    <= '0;
            acc_q    <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            z_q      <= z_d;
            ovf_q    <= ovf_d;
            acc_q    <= acc_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    // Outputs come straight from the last stage.
    always_comb begin
        out_valid = valid_q[LAST];
        Z         = z_q[LAST];
        ovf       = ovf_q[LAST];
        res_count = cnt_q;
    end

endmodule

// File: tb/tb_padder_acc.sv
// Bench for padder_acc: four instances (S2, S2 with broken carry, S1, S4),
// vector tables, hand sequences and a per-instance scoreboard model.
module tb_padder_acc;

    localparam int unsigned W  = 4;
    localparam int unsigned ZW = W + 1;

    logic           clk;
    logic           rst_n;
    logic           out_ready;
    logic           mode;
    logic           clear;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [3:0]     in_valid;
    logic [3:0]     in_ready;
    logic [3:0]     out_valid;
    logic [3:0]     ovf_o;
    logic [ZW-1:0]  z_o   [4];
    logic [15:0]    cnt_o [4];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit chk_lat = 0;

    typedef struct {
        bit m;
        bit c;
        int a;
        int b;
        int z;
        int ov;
    } vec_t;

    vec_t tbl_main [9];
    vec_t tbl_ce   [3];

    int            hs;
    bit            done;
    int            sent;
    int            got [$];
    logic [ZW-1:0] zprev;
    bit            stalled_prev;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int stg(input int g);
        return (g == 2) ? 1 : ((g == 3) ? 4 : 2);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Instances plus a scoreboard that models each from the arithmetic rules.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned GS  = (g == 2) ? 1 : ((g == 3) ? 4 : 2);
        localparam int unsigned GCE = (g == 1) ? 1 : 0;

        typedef struct {
            int z;
            int ov;
            int c;
        } exp_t;

        exp_t q [$];
        int   acc = 0;
        int   st  = 0;

        padder_acc #(.WIDTH(W), .STAGES(GS), .CARRY_ERROR(GCE)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .A         (a),
            .B         (b),
            .mode      (mode),
            .clear     (clear),
            .out_valid (out_valid[g]),
            .out_ready (out_ready),
            .Z         (z_o[g]),
            .ovf       (ovf_o[g]),
            .res_count (cnt_o[g])
        );

        always @(negedge clk) begin : mon
            exp_t e;
            int   t;
            if (!rst_n) begin
                q.delete();
                acc = 0;
                st  = 0;
            end else begin
                if (out_valid[g] && out_ready) begin
                    if (q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL sb%0d_extra: got Z=%0d with no beat outstanding", g, z_o[g]);
                    end else begin
                        e = q.pop_front();
                        check($sformatf("sb%0d_z", g), int'(z_o[g]), e.z);
                        check($sformatf("sb%0d_ovf", g), int'(ovf_o[g]), e.ov);
                        if (chk_lat) check($sformatf("sb%0d_latency", g), cyc - e.c, GS);
                    end
                end
                if (in_valid[g] && in_ready[g]) begin
                    if (clear) begin
                        acc = 0;
                        st  = 0;
                    end
                    if (!mode) begin
                        e.z  = (int'(a) + int'(b)) % ((GCE != 0) ? 2**W : 2**(W+1));
                        e.ov = st;
                    end else begin
                        t   = acc + int'(a) + int'(b);
                        acc = t % 2**(W+1);
                        if (GCE != 0) acc = acc % 2**W;
                        st   = (st != 0 || t >= 2**(W+1)) ? 1 : 0;
                        e.z  = acc;
                        e.ov = st;
                    end
                    e.c = cyc;
                    q.push_back(e);
                end
            end
        end
    end

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = '0;
        chk_lat  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One isolated beat into instance g, checking exact latency and result.
    task automatic apply_vec(input int g, input vec_t v, input string tag);
        mode        = v.m;
        clear       = v.c;
        a           = W'(v.a);
        b           = W'(v.b);
        in_valid[g] = 1'b1;
        @(negedge clk);
        check({tag, "_in_ready"}, int'(in_ready[g]), 1);
        @(posedge clk);
        #1;
        in_valid[g] = 1'b0;
        for (int k = 1; k < stg(g); k++) begin
            @(negedge clk);
            check({tag, "_early_valid"}, int'(out_valid[g]), 0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check({tag, "_valid"}, int'(out_valid[g]), 1);
        check({tag, "_z"}, int'(z_o[g]), v.z);
        check({tag, "_ovf"}, int'(ovf_o[g]), v.ov);
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl_main[0] = '{0, 0,  9,  8, 17, 0};
        tbl_main[1] = '{1, 1, 15, 15, 30, 0};
        tbl_main[2] = '{1, 0,  1,  0, 31, 0};
        tbl_main[3] = '{1, 0,  1,  0,  0, 1};
        tbl_main[4] = '{1, 0,  0,  0,  0, 1};
        tbl_main[5] = '{0, 0,  3,  4,  7, 1};
        tbl_main[6] = '{0, 1,  3,  4,  7, 0};
        tbl_main[7] = '{1, 0,  5,  6, 11, 0};
        tbl_main[8] = '{1, 1,  2,  0,  2, 0};
        tbl_ce[0]   = '{0, 0,  9,  8,  1, 0};
        tbl_ce[1]   = '{1, 1, 15, 15, 14, 0};
        tbl_ce[2]   = '{1, 0, 15, 15, 12, 1};

        out_ready = 1'b1;
        mode      = 1'b0;
        clear     = 1'b0;
        a         = '0;
        b         = '0;
        in_valid  = '0;

        // Reset values, observed while reset is still asserted.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) begin
            check($sformatf("rst%0d_in_ready", g), int'(in_ready[g]), 1);
            check($sformatf("rst%0d_out_valid", g), int'(out_valid[g]), 0);
            check($sformatf("rst%0d_z", g), int'(z_o[g]), 0);
            check($sformatf("rst%0d_ovf", g), int'(ovf_o[g]), 0);
            check($sformatf("rst%0d_count", g), int'(cnt_o[g]), 0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Vector tables: add/accumulate/clear rules and the broken carry.
        for (int i = 0; i < 9; i++) apply_vec(0, tbl_main[i], $sformatf("tbl%0d", i));
        for (int i = 0; i < 3; i++) apply_vec(1, tbl_ce[i], $sformatf("ce%0d", i));

        // Backpressure: six add beats, consumer stalls in cycles 3..5.
        do_reset();
        mode  = 1'b0;
        clear = 1'b0;
        sent  = 0;
        got.delete();
        stalled_prev = 1'b0;
        zprev = '0;
        for (int k = 0; k < 16; k++) begin
            out_ready   = !(k >= 3 && k <= 5);
            in_valid[0] = (sent < 6);
            a           = W'(sent);
            b           = W'(sent);
            @(negedge clk);
            check("bp_in_ready", int'(in_ready[0]), int'(!(out_valid[0] && !out_ready)));
            if (stalled_prev) begin
                check("bp_hold_valid", int'(out_valid[0]), 1);
                check("bp_hold_z", int'(z_o[0]), int'(zprev));
            end
            stalled_prev = out_valid[0] && !out_ready;
            zprev        = z_o[0];
            if (out_valid[0] && out_ready) got.push_back(int'(z_o[0]));
            if (in_valid[0] && in_ready[0]) sent++;
            @(posedge clk);
            #1;
        end
        in_valid[0] = 1'b0;
        out_ready   = 1'b1;
        check("bp_out_count", got.size(), 6);
        for (int i = 0; i < got.size() && i < 6; i++) check($sformatf("bp_out%0d", i), got[i], 2 * i);
        check("bp_res_count", int'(cnt_o[0]), 6);

        // Full throughput with random beats on STAGES = 2, 1, 4.
        for (int s = 0; s < 3; s++) begin
            int g;
            g = (s == 0) ? 0 : ((s == 1) ? 2 : 3);
            do_reset();
            chk_lat   = 1'b1;
            out_ready = 1'b1;
            for (int k = 0; k < 20 + stg(g); k++) begin
                in_valid[g] = (k < 20);
                mode        = 1'($urandom_range(0, 1));
                clear       = ($urandom_range(0, 7) == 0);
                a           = W'($urandom_range(0, 15));
                b           = W'($urandom_range(0, 15));
                @(negedge clk);
                check($sformatf("tp%0d_in_ready", g), int'(in_ready[g]), 1);
                check($sformatf("tp%0d_out_valid", g), int'(out_valid[g]), int'(k >= stg(g)));
                @(posedge clk);
                #1;
            end
            in_valid[g] = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            check($sformatf("tp%0d_res_count", g), int'(cnt_o[g]), 20);
            chk_lat = 1'b0;
        end

        // Reset mid-stream with two beats in flight; accumulator must be gone.
        do_reset();
        out_ready   = 1'b1;
        mode        = 1'b1;
        clear       = 1'b0;
        a           = W'(5);
        b           = '0;
        in_valid[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        check("mid_pre_valid", int'(out_valid[0]), 1);
        check("mid_pre_count", int'(cnt_o[0]), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(out_valid[0]), 0);
        check("mid_rst_z", int'(z_o[0]), 0);
        check("mid_rst_count", int'(cnt_o[0]), 0);
        check("mid_rst_in_ready", int'(in_ready[0]), 1);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply_vec(0, '{1, 0, 3, 0, 3, 0}, "mid_after");

        // Counter wrap: 65537 handshakes.
        do_reset();
        out_ready   = 1'b1;
        mode        = 1'b0;
        clear       = 1'b0;
        in_valid[0] = 1'b1;
        hs          = 0;
        done        = 1'b0;
        for (int k = 0; k < 65600 && !done; k++) begin
            a = W'($urandom_range(0, 15));
            b = W'($urandom_range(0, 15));
            @(negedge clk);
            if (out_valid[0] && out_ready) hs++;
            @(posedge clk);
            #1;
            if (hs == 65535) check("wrap_65535", int'(cnt_o[0]), 65535);
            else if (hs == 65536) check("wrap_0", int'(cnt_o[0]), 0);
            else if (hs == 65537) begin
                check("wrap_1", int'(cnt_o[0]), 1);
                done = 1'b1;
            end
        end
        in_valid[0] = 1'b0;
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL wrap_timeout: got %0d handshakes expected 65537", hs);
        end

        repeat (6) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
